ula_ctrl: RTL and testbench

- Dispatch stage directly upstream of the ULA.
- Accepts one operation per valid/ready handshake (op_sel, op1, op2) and drives the ULA's ena/op_sel/op1/op2.
- Waits for ula_ack, captures res, and presents the result downstream on a second valid/ready handshake.
- Filters the reserved op_sel codes 00xx, which the ULA treats as default and returns 0 for.

---
 rtl/ula_pkg.sv | 37 +++
 rtl/ula_ctrl_wdog.sv | 38 +++
 rtl/ula_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_ula_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ula_pkg.sv
// ula_pkg: shared definitions for the ULA dispatch controller.
//   ULA_WIDTH / ULA_SEL_W : default operand and op_sel widths
//   OP_*                  : op_sel codes understood by the ULA (z bits are wildcards)
//   state_t               : controller state encoding (IDLE / EXEC / OUT)
//   is_legal_sel()        : 1 when an op_sel is worth dispatching to the ULA
package ula_pkg;

    localparam int ULA_WIDTH = 4;
    localparam int ULA_SEL_W = 4;

    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_NAND = 4'b0111;
    localparam logic [3:0] OP_ADD  = 4'b10zz;
    localparam logic [3:0] OP_SUB  = 4'b11zz;
    localparam logic [3:0] OP_RSVD = 4'b00zz;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

    // The 00xx codes fall into the ULA's default branch and only ever
    // produce 0, so they are answered locally instead of being dispatched.
    function automatic logic is_legal_sel(input logic [3:0] sel);
        logic ok;
        ok = 1'b0;
        casez (sel)
            OP_OR, OP_AND, OP_XOR, OP_NAND, OP_ADD, OP_SUB: ok = 1'b1;
            default:                                        ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ula_ctrl_wdog.sv
// ula_ctrl_wdog: EXEC-state watchdog for ula_ctrl (used only when
// ULA_CTRL_TIMEOUT_EN is defined).
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : a legal operation is being accepted (EXEC is entered next)
//   exec       : controller is in EXEC
//   ack        : ULA acknowledge
//   expired    : this edge is the TIMEOUT_CYC-th EXEC edge without ack
module ula_ctrl_wdog #(
    parameter int TIMEOUT_CYC = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic exec,
    input  logic ack,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] cnt;

    // Counts EXEC edges that saw no ack; restarted whenever EXEC is entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= '0;
        end else if (exec && !ack) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Fires on the edge that would bring the count to TIMEOUT_CYC; an ack on
    // that same edge suppresses it so a late completion is never lost.
    assign expired = exec && !ack && (cnt == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/ula_ctrl.sv
// ula_ctrl: dispatch stage in front of the ULA.
// Takes one operation per in_valid/in_ready handshake, drives the ULA until it
// acks, and offers the captured result on an out_valid/out_ready handshake.
// Reserved op_sel codes (00xx) are answered locally with res=0, illegal=1.
//   clk, rst_n                    : clock, asynchronous active-low reset
//   in_valid/in_ready             : upstream handshake
//   in_op_sel, in_op1, in_op2     : requested operation
//   ula_ena, ula_op_sel/op1/op2   : ULA drive (held stable while enabled)
//   ula_res, ula_ack              : ULA response
//   out_valid/out_ready           : downstream handshake
//   out_res, out_op_sel           : captured result and the op_sel behind it
//   out_illegal                   : op_sel was reserved, ULA not used
//   out_err                       : EXEC timed out (optional feature)
//   busy                          : controller not idle
//   op_count                      : completed output handshakes (wraps)
// Optional feature macro: ULA_CTRL_TIMEOUT_EN enables the EXEC watchdog.
module ula_ctrl
    import ula_pkg::*;
#(
    parameter int WIDTH       = ula_pkg::ULA_WIDTH,
    parameter int SEL_W       = ula_pkg::ULA_SEL_W,
    parameter int TIMEOUT_CYC = 15,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] in_op_sel,
    input  logic [WIDTH-1:0] in_op1,
    input  logic [WIDTH-1:0] in_op2,
    output logic             ula_ena,
    output logic [SEL_W-1:0] ula_op_sel,
    output logic [WIDTH-1:0] ula_op1,
    output logic [WIDTH-1:0] ula_op2,
    input  logic [WIDTH-1:0] ula_res,
    input  logic             ula_ack,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic [SEL_W-1:0] out_op_sel,
    output logic             out_illegal,
    output logic             out_err,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    state_t state;
    state_t state_nx;

    logic accept;
    logic out_hs;
    logic legal_in;
    logic done_ack;
    logic abort;

    // in_ready is gated by rst_n so it reads 0 while reset is held, and it
    // looks through out_ready so a result can be retired and a new
    // operation taken in the same cycle.
    assign in_ready = rst_n && ((state == ST_IDLE) || ((state == ST_OUT) && out_ready));
    assign accept   = in_valid && in_ready;
    assign out_hs   = (state == ST_OUT) && out_ready;
    assign legal_in = is_legal_sel(in_op_sel);
    assign done_ack = (state == ST_EXEC) && ula_ack;

    assign ula_ena   = (state == ST_EXEC);
    assign out_valid = (state == ST_OUT);
    assign busy      = (state != ST_IDLE);

`ifdef ULA_CTRL_TIMEOUT_EN
    logic wdog_expired;

    ula_ctrl_wdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (accept && legal_in),
        .exec    (state == ST_EXEC),
        .ack     (ula_ack),
        .expired (wdog_expired)
    );

    assign abort = wdog_expired;

    // The error flag describes the result currently on offer, so it lives
    // until the next operation is taken in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_err <= 1'b0;
        end else if (accept) begin
            out_err <= 1'b0;
        end else if (abort) begin
            out_err <= 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = (TIMEOUT_CYC == 0);
    assign abort          = 1'b0;
    assign out_err        = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state: an accept goes to EXEC for real ops and straight to OUT for
    // reserved ones, whether it happens from IDLE or back-to-back from OUT.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nx = legal_in ? ST_EXEC : ST_OUT;
                end
            end
            ST_EXEC: begin
                if (ula_ack || abort) begin
                    state_nx = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_hs) begin
                    if (accept) begin
                        state_nx = legal_in ? ST_EXEC : ST_OUT;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // ULA drive registers are loaded only for operations that really go to
    // the ULA, so a reserved op never disturbs what the ULA last saw.
    // Result registers change only on an accept (which in OUT implies the
    // old result was just taken) or on leaving EXEC, keeping them stable
    // for as long as out_valid is up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ula_op_sel  <= '0;
            ula_op1     <= '0;
            ula_op2     <= '0;
            out_res     <= '0;
            out_op_sel  <= '0;
            out_illegal <= 1'b0;
            op_count    <= '0;
        end else begin
            if (accept && legal_in) begin
                ula_op_sel <= in_op_sel;
                ula_op1    <= in_op1;
                ula_op2    <= in_op2;
            end
            if (accept && !legal_in) begin
                out_res     <= '0;
                out_op_sel  <= in_op_sel;
                out_illegal <= 1'b1;
            end else if (done_ack) begin
                out_res     <= ula_res;
                out_op_sel  <= ula_op_sel;
                out_illegal <= 1'b0;
            end else if (abort) begin
                out_res     <= '0;
                out_op_sel  <= ula_op_sel;
                out_illegal <= 1'b0;
            end
            if (out_hs) begin
                op_count <= op_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ula_ctrl.sv
// tb_ula_ctrl: directed self-checking bench for ula_ctrl with a small ULA
// responder model attached. Define ULA_CTRL_TIMEOUT_EN to also exercise the
// watchdog (DUT built with TIMEOUT_CYC=3).
module tb_ula_ctrl;
    import ula_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_op_sel;
    logic [3:0] in_op1;
    logic [3:0] in_op2;
    logic       ula_ena;
    logic [3:0] ula_op_sel;
    logic [3:0] ula_op1;
    logic [3:0] ula_op2;
    logic [3:0] ula_res;
    logic       ula_ack;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_res;
    logic [3:0] out_op_sel;
    logic       out_illegal;
    logic       out_err;
    logic       busy;
    logic [7:0] op_count;

    // Responder controls and the two ack sources it is muxed with.
    logic       resp_en;
    int         ack_delay;
    int         ena_cnt;
    logic       resp_ack;
    logic [3:0] resp_res;
    logic       force_ack;
    logic [3:0] force_res;

    int total;
    int bad;

    assign ula_ack = resp_en ? resp_ack : force_ack;
    assign ula_res = resp_en ? resp_res : force_res;

    ula_ctrl #(
        .WIDTH       (4),
        .SEL_W       (4),
        .TIMEOUT_CYC (3),
        .CNT_W       (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op_sel   (in_op_sel),
        .in_op1      (in_op1),
        .in_op2      (in_op2),
        .ula_ena     (ula_ena),
        .ula_op_sel  (ula_op_sel),
        .ula_op1     (ula_op1),
        .ula_op2     (ula_op2),
        .ula_res     (ula_res),
        .ula_ack     (ula_ack),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_res     (out_res),
        .out_op_sel  (out_op_sel),
        .out_illegal (out_illegal),
        .out_err     (out_err),
        .busy        (busy),
        .op_count    (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ULA.
    function automatic logic [3:0] ula_model(input logic [3:0] sel, input logic [3:0] a,
                                             input logic [3:0] b);
        logic [3:0] r;
        r = 4'd0;
        casez (sel)
            OP_OR:   r = a | b;
            OP_AND:  r = a & b;
            OP_XOR:  r = a ^ b;
            OP_NAND: r = ~(a & b);
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            default: r = 4'd0;
        endcase
        return r;
    endfunction

    // Acks ack_delay negedges after ula_ena rises; drops ack once ena falls.
    always @(negedge clk) begin
        if (ula_ena) begin
            if (ena_cnt >= ack_delay) begin
                resp_ack = 1'b1;
                resp_res = ula_model(ula_op_sel, ula_op1, ula_op2);
            end
            ena_cnt = ena_cnt + 1;
        end else begin
            resp_ack = 1'b0;
            ena_cnt  = 0;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp)
        else begin
            bad = bad + 1;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents one operation and waits (bounded) until it is accepted.
    // Returns 1 time unit after the accepting edge with in_valid dropped.
    task automatic applyStimulus(input logic [3:0] sel, input logic [3:0] a, input logic [3:0] b);
        int n;
        in_valid  = 1'b1;
        in_op_sel = sel;
        in_op1    = a;
        in_op2    = b;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n = n + 1;
        end
        checkOutput("accept_wait", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_op_sel = 4'd0;
        in_op1    = 4'd0;
        in_op2    = 4'd0;
        out_ready = 1'b1;
        resp_en   = 1'b1;
        ack_delay = 0;
        ena_cnt   = 0;
        resp_ack  = 1'b0;
        resp_res  = 4'd0;
        force_ack = 1'b0;
        force_res = 4'd0;

        // Reset state.
        #3;
        checkOutput("rst_in_ready", 32'(in_ready), 0);
        checkOutput("rst_out_valid", 32'(out_valid), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_ula_ena", 32'(ula_ena), 0);
        checkOutput("rst_op_count", 32'(op_count), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("idle_in_ready", 32'(in_ready), 1);

        // Single OR op: 1010 | 0101 = 1111.
        $display("[TB] single op");
        applyStimulus(4'b0100, 4'b1010, 4'b0101);
        checkOutput("t1_exec_ena", 32'(ula_ena), 1);
        checkOutput("t1_exec_busy", 32'(busy), 1);
        checkOutput("t1_exec_sel", 32'(ula_op_sel), 32'h4);
        checkOutput("t1_exec_op1", 32'(ula_op1), 32'hA);
        checkOutput("t1_exec_op2", 32'(ula_op2), 32'h5);
        checkOutput("t1_exec_ovalid", 32'(out_valid), 0);
        checkOutput("t1_exec_inready", 32'(in_ready), 0);
        step();
        checkOutput("t1_out_valid", 32'(out_valid), 1);
        checkOutput("t1_out_res", 32'(out_res), 32'hF);
        checkOutput("t1_out_sel", 32'(out_op_sel), 32'h4);
        checkOutput("t1_out_illegal", 32'(out_illegal), 0);
        checkOutput("t1_out_err", 32'(out_err), 0);
        checkOutput("t1_out_ena", 32'(ula_ena), 0);
        checkOutput("t1_out_cnt", 32'(op_count), 0);
        step();
        checkOutput("t1_done_cnt", 32'(op_count), 1);
        checkOutput("t1_done_valid", 32'(out_valid), 0);
        checkOutput("t1_done_busy", 32'(busy), 0);

        // Backpressure: SUB 9-5 = 0100 held while out_ready=0.
        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(4'b1100, 4'd9, 4'd5);
        step();
        for (int i = 0; i < 5; i++) begin
            checkOutput("t2_hold_valid", 32'(out_valid), 1);
            checkOutput("t2_hold_res", 32'(out_res), 32'h4);
            checkOutput("t2_hold_inready", 32'(in_ready), 0);
            step();
        end
        checkOutput("t2_hold_cnt", 32'(op_count), 1);
        out_ready = 1'b1;
        #1;
        checkOutput("t2_rel_inready", 32'(in_ready), 1);
        step();
        checkOutput("t2_done_cnt", 32'(op_count), 2);
        checkOutput("t2_done_busy", 32'(busy), 0);

        // Back-to-back: ADD 6+3 = 1001, then AND 1100&1010 = 1000.
        $display("[TB] back-to-back");
        out_ready = 1'b0;
        applyStimulus(4'b1000, 4'd6, 4'd3);
        step();
        checkOutput("t3_first_res", 32'(out_res), 32'h9);
        checkOutput("t3_first_valid", 32'(out_valid), 1);
        in_valid  = 1'b1;
        in_op_sel = 4'b0101;
        in_op1    = 4'b1100;
        in_op2    = 4'b1010;
        out_ready = 1'b1;
        #1;
        checkOutput("t3_b2b_inready", 32'(in_ready), 1);
        step();
        in_valid = 1'b0;
        checkOutput("t3_b2b_cnt", 32'(op_count), 3);
        checkOutput("t3_b2b_busy", 32'(busy), 1);
        checkOutput("t3_b2b_ena", 32'(ula_ena), 1);
        checkOutput("t3_b2b_sel", 32'(ula_op_sel), 32'h5);
        step();
        checkOutput("t3_second_valid", 32'(out_valid), 1);
        checkOutput("t3_second_res", 32'(out_res), 32'h8);
        step();
        checkOutput("t3_done_cnt", 32'(op_count), 4);

        // Reserved op_sel 0000: answered locally one cycle after accept.
        $display("[TB] illegal op");
        out_ready = 1'b0;
        applyStimulus(4'b0000, 4'd7, 4'd2);
        checkOutput("t4_valid", 32'(out_valid), 1);
        checkOutput("t4_res", 32'(out_res), 0);
        checkOutput("t4_illegal", 32'(out_illegal), 1);
        checkOutput("t4_sel", 32'(out_op_sel), 0);
        checkOutput("t4_ena", 32'(ula_ena), 0);
        checkOutput("t4_ula_sel_held", 32'(ula_op_sel), 32'h5);
        step();
        checkOutput("t4_ena_later", 32'(ula_ena), 0);
        checkOutput("t4_res_stable", 32'(out_res), 0);
        out_ready = 1'b1;
        step();
        checkOutput("t4_done_cnt", 32'(op_count), 5);

        // Reset while EXEC waits on a slow ULA.
        $display("[TB] reset mid-exec");
        ack_delay = 4;
        applyStimulus(4'b0110, 4'd3, 4'd5);
        step();
        step();
        checkOutput("t5_pre_ena", 32'(ula_ena), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_ena", 32'(ula_ena), 0);
        checkOutput("t5_rst_busy", 32'(busy), 0);
        checkOutput("t5_rst_inready", 32'(in_ready), 0);
        checkOutput("t5_rst_sel", 32'(ula_op_sel), 0);
        checkOutput("t5_rst_op1", 32'(ula_op1), 0);
        checkOutput("t5_rst_cnt", 32'(op_count), 0);
        @(negedge clk);
        resp_en   = 1'b0;
        force_ack = 1'b1;
        force_res = 4'hF;
        rst_n     = 1'b1;
        #1;
        checkOutput("t5_rel_inready", 32'(in_ready), 1);
        step();
        step();
        checkOutput("t5_stale_busy", 32'(busy), 0);
        checkOutput("t5_stale_valid", 32'(out_valid), 0);
        checkOutput("t5_stale_res", 32'(out_res), 0);
        force_ack = 1'b0;
        resp_en   = 1'b1;
        ack_delay = 0;

`ifdef ULA_CTRL_TIMEOUT_EN
        // Watchdog abort after 3 EXEC cycles with no ack.
        $display("[TB] timeout abort");
        resp_en   = 1'b0;
        out_ready = 1'b0;
        applyStimulus(4'b0100, 4'd1, 4'd2);
        step();
        step();
        checkOutput("t6_wait_ena", 32'(ula_ena), 1);
        checkOutput("t6_wait_valid", 32'(out_valid), 0);
        step();
        checkOutput("t6_abort_valid", 32'(out_valid), 1);
        checkOutput("t6_abort_err", 32'(out_err), 1);
        checkOutput("t6_abort_res", 32'(out_res), 0);
        step();
        checkOutput("t6_err_held", 32'(out_err), 1);

        // Ack on the abort edge is a normal completion: 1111 & 0110 = 0110.
        resp_en   = 1'b1;
        ack_delay = 2;
        out_ready = 1'b1;
        #1;
        applyStimulus(4'b0101, 4'b1111, 4'b0110);
        out_ready = 1'b0;
        checkOutput("t6_err_cleared", 32'(out_err), 0);
        step();
        step();
        step();
        checkOutput("t6_late_valid", 32'(out_valid), 1);
        checkOutput("t6_late_err", 32'(out_err), 0);
        checkOutput("t6_late_res", 32'(out_res), 32'h6);
        out_ready = 1'b1;
        step();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
